// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared widths, loader state encodings, loader types
//
// Shared header for the instruction-memory loader. The `define block carries
// the datapath widths and the loader FSM encodings so benches can probe the
// state. The package turns them into typed constants for the RTL.
`ifndef IMEM_LOADER_DEFS
`define IMEM_LOADER_DEFS
`define DWIDTH    32
`define PC_WIDTH  32
`define LD_LEN_HI 3'd0
`define LD_LEN_LO 3'd1
`define LD_DATA   3'd2
`define LD_DONE   3'd3
`define LD_ERR    3'd4
`endif

package imem_loader_pkg;

    localparam int LD_DW = `DWIDTH;
    localparam int LD_AW = `PC_WIDTH;

    typedef enum logic [2:0] {
        ST_LEN_HI = `LD_LEN_HI,
        ST_LEN_LO = `LD_LEN_LO,
        ST_DATA   = `LD_DATA,
        ST_DONE   = `LD_DONE,
        ST_ERR    = `LD_ERR
    } ld_state_e;

    // Word index to byte address.
    function automatic logic [LD_AW-1:0] word_addr(input logic [LD_AW-1:0] idx);
        return idx << 2;
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - 8-to-32 big-endian word assembler
//
// Ports:
//   clk_i, rst_i    : clock, synchronous active-high reset
//   clr_i           : drop any partial word and restart the byte count
//   shift_i         : a data byte is accepted this cycle
//   byte_i          : the accepted byte
//   word_o          : assembled word (valid while done_o is high)
//   done_o          : this cycle's byte completes a word
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic [7:0]       byte_i,
    output logic [LD_DW-1:0] word_o,
    output logic             done_o
);

    logic [23:0] sr_q, sr_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (shift_i) begin
            sr_d  = {sr_q[15:0], byte_i};
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    // The fourth byte is combined with the three held bytes directly, so the
    // loader can register the complete word on the same edge it is accepted.
    assign word_o = {sr_q, byte_i};
    assign done_o = shift_i && !clr_i && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream writer for instruction memory
//
// Ports:
//   l_clk, l_rst        : clock, synchronous active-high reset
//   l_i_valid, l_i_byte : byte stream in; l_o_ready accepts it
//   l_i_reload          : pulse that aborts/restarts loading (beats a transfer)
//   l_o_we, l_o_waddr,
//   l_o_wdata           : instruction-memory write port (byte address)
//   l_o_done, l_o_err   : program loaded / length exceeded DEPTH
//   l_o_core_rst_n      : datapath reset, released once loading is done
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic             l_clk,
    input  logic             l_rst,
    input  logic             l_i_valid,
    input  logic [7:0]       l_i_byte,
    output logic             l_o_ready,
    input  logic             l_i_reload,
    output logic             l_o_we,
    output logic [LD_AW-1:0] l_o_waddr,
    output logic [LD_DW-1:0] l_o_wdata,
    output logic             l_o_done,
    output logic             l_o_err,
    output logic             l_o_core_rst_n
);

    localparam int IW = $clog2(DEPTH) + 1;

    ld_state_e        state_q;
    logic             ready_q;
    logic             we_q;
    logic [LD_AW-1:0] waddr_q;
    logic [LD_DW-1:0] wdata_q;
    logic             done_q;
    logic             err_q;
    logic             core_rst_n_q;
    logic [IW-1:0]    widx_q;
    logic [15:0]      nlen_q;
    logic [7:0]       len_hi_q;

    logic             xfer;
    logic [15:0]      n_w;
    logic             asm_clr;
    logic             asm_shift;
    logic [LD_DW-1:0] asm_word;
    logic             asm_done;

    // ready_q is the registered handshake, so it is also the acceptance term.
    assign xfer      = l_i_valid && ready_q && !l_i_reload;
    assign n_w       = {len_hi_q, l_i_byte};
    assign asm_clr   = l_i_reload || (state_q == ST_LEN_LO && xfer);
    assign asm_shift = (state_q == ST_DATA) && xfer;

    word_assembler u_asm (
        .clk_i   (l_clk),
        .rst_i   (l_rst),
        .clr_i   (asm_clr),
        .shift_i (asm_shift),
        .byte_i  (l_i_byte),
        .word_o  (asm_word),
        .done_o  (asm_done)
    );

    always_ff @(posedge l_clk) begin
        if (l_rst) begin
            state_q      <= ST_LEN_HI;
            ready_q      <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
            widx_q       <= '0;
            nlen_q       <= '0;
            len_hi_q     <= '0;
        end else begin
            we_q <= 1'b0;
            if (l_i_reload) begin
                state_q      <= ST_LEN_HI;
                ready_q      <= 1'b1;
                done_q       <= 1'b0;
                err_q        <= 1'b0;
                core_rst_n_q <= 1'b0;
                widx_q       <= '0;
                nlen_q       <= '0;
            end else begin
                case (state_q)
                    ST_LEN_HI: begin
                        ready_q <= 1'b1;
                        if (xfer) begin
                            len_hi_q <= l_i_byte;
                            state_q  <= ST_LEN_LO;
                        end
                    end
                    ST_LEN_LO: begin
                        if (xfer) begin
                            nlen_q <= n_w;
                            widx_q <= '0;
                            if (n_w == 16'd0) begin
                                state_q      <= ST_DONE;
                                ready_q      <= 1'b0;
                                done_q       <= 1'b1;
                                core_rst_n_q <= 1'b1;
                            end else if (32'(n_w) > 32'(DEPTH)) begin
                                state_q <= ST_ERR;
                                ready_q <= 1'b0;
                                err_q   <= 1'b1;
                            end else begin
                                state_q <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (asm_done) begin
                            we_q    <= 1'b1;
                            wdata_q <= asm_word;
                            waddr_q <= word_addr(LD_AW'(widx_q));
                            widx_q  <= widx_q + IW'(1);
                            // Last word: done follows one cycle after the write.
                            if (32'(widx_q) == 32'(nlen_q) - 32'd1) begin
                                state_q <= ST_DONE;
                                ready_q <= 1'b0;
                            end
                        end
                    end
                    ST_DONE: begin
                        ready_q      <= 1'b0;
                        done_q       <= 1'b1;
                        core_rst_n_q <= 1'b1;
                    end
                    ST_ERR: begin
                        ready_q <= 1'b0;
                        err_q   <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_LEN_HI;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign l_o_ready      = ready_q;
    assign l_o_we         = we_q;
    assign l_o_waddr      = waddr_q;
    assign l_o_wdata      = wdata_q;
    assign l_o_done       = done_q;
    assign l_o_err        = err_q;
    assign l_o_core_rst_n = core_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [7:0]  bdat = 8'h00;
    logic        reload = 1'b0;
    logic        ready, we, done, err, core_rst_n;
    logic [31:0] waddr, wdata;

    logic        v4 = 1'b0;
    logic [7:0]  b4 = 8'h00;
    logic        r4 = 1'b0;
    logic        ready4, we4, done4, err4, core_rst_n4;
    logic [31:0] waddr4, wdata4;

    int vectors = 0;
    int miscompares = 0;
    int writes4 = 0;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    imem_loader dut (
        .l_clk(clk), .l_rst(rst), .l_i_valid(valid), .l_i_byte(bdat),
        .l_o_ready(ready), .l_i_reload(reload), .l_o_we(we),
        .l_o_waddr(waddr), .l_o_wdata(wdata), .l_o_done(done),
        .l_o_err(err), .l_o_core_rst_n(core_rst_n)
    );

    imem_loader #(.DEPTH(4)) dut4 (
        .l_clk(clk), .l_rst(rst), .l_i_valid(v4), .l_i_byte(b4),
        .l_o_ready(ready4), .l_i_reload(r4), .l_o_we(we4),
        .l_o_waddr(waddr4), .l_o_wdata(wdata4), .l_o_done(done4),
        .l_o_err(err4), .l_o_core_rst_n(core_rst_n4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe pops one expected write.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %h data %h expected none", waddr, wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("waddr", waddr, e.addr);
                chk("wdata", wdata, e.data);
            end
        end
        if (we4 === 1'b1) writes4++;
    end

    // Present one byte and hold it until accepted; returns on the negedge after.
    task automatic send(input logic [7:0] b);
        int t = 0;
        valid = 1'b1;
        bdat  = b;
        while (ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("ready_timeout", {31'd0, ready}, 32'd1);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        bdat  = 8'hA5;   // junk under valid=0 must be ignored
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    logic [7:0] s2[10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                           8'h21, 8'h29, 8'h00, 8'h01};

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_waddr", waddr, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_core", {31'd0, core_rst_n}, 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(`LD_LEN_HI));
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, ready}, 32'd1);

        // DEPTH=4 unit: length 5 overflows
        v4 = 1'b1; b4 = 8'h00;
        @(negedge clk);
        b4 = 8'h05;
        @(negedge clk);
        v4 = 1'b0;
        chk("d4_err", {31'd0, err4}, 32'd1);
        chk("d4_ready", {31'd0, ready4}, 32'd0);
        chk("d4_core", {31'd0, core_rst_n4}, 32'd0);
        chk("d4_state", 32'(dut4.state_q), 32'(`LD_ERR));

        // Two-word program, back to back
        exp_q.push_back('{32'h0, 32'h20080005});
        exp_q.push_back('{32'h4, 32'h21290001});
        foreach (s2[i]) send(s2[i]);
        chk("t1_we_last", {31'd0, we}, 32'd1);
        chk("t1_done_early", {31'd0, done}, 32'd0);
        chk("t1_ready_drop", {31'd0, ready}, 32'd0);
        @(negedge clk);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_core", {31'd0, core_rst_n}, 32'd1);
        chk("t1_ready", {31'd0, ready}, 32'd0);
        chk("t1_sb_empty", exp_q.size(), 32'd0);

        // Reload from DONE, with a valid byte in the same cycle
        reload = 1'b1; valid = 1'b1; bdat = 8'h7F;
        @(negedge clk);
        reload = 1'b0; valid = 1'b0;
        chk("rl_core", {31'd0, core_rst_n}, 32'd0);
        chk("rl_ready", {31'd0, ready}, 32'd1);
        chk("rl_done", {31'd0, done}, 32'd0);
        chk("rl_state", 32'(dut.state_q), 32'(`LD_LEN_HI));

        // Same program with idle gaps
        exp_q.push_back('{32'h0, 32'h20080005});
        exp_q.push_back('{32'h4, 32'h21290001});
        foreach (s2[i]) begin
            send(s2[i]);
            if (i != 9) idle(1);
        end
        @(negedge clk);
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_sb_empty", exp_q.size(), 32'd0);

        // Empty program
        pulse_reload();
        send(8'h00);
        send(8'h00);
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_core", {31'd0, core_rst_n}, 32'd1);
        idle(3);

        // Partial word aborted by reload, then one-word program
        pulse_reload();
        send(8'h00); send(8'h01); send(8'h11); send(8'h22);
        pulse_reload();
        chk("t4_core_abort", {31'd0, core_rst_n}, 32'd0);
        exp_q.push_back('{32'h0, 32'hDEADBEEF});
        send(8'h00); send(8'h01); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        @(negedge clk);
        chk("t4_done", {31'd0, done}, 32'd1);
        idle(3);
        chk("t4_sb_empty", exp_q.size(), 32'd0);
        chk("d4_no_writes", writes4, 32'd0);
        chk("d4_err_hold", {31'd0, err4}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
